// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the MIPS control/datapath and the mult/div unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_we, lo_we, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hi_we, lo_we, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Works on operand magnitudes for WIDTH cycles, then fixes signs in one cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d, div_zero_q, div_zero_d;

  logic              sgn_in;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [WIDTH:0]    sum, rem_try;
  logic [W2:0]       sh;
  logic [W2-1:0]     prod;
  logic [WIDTH-1:0]  quo, rem, a_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    // Ops with op[0]==0 are the signed flavours; -0x80000000 wraps to itself.
    sgn_in  = ~bus.op[0];
    a_abs   = (sgn_in && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    b_abs   = (sgn_in && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    sum     = '0;
    rem_try = '0;
    sh      = '0;
    prod    = acc_q;
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[W2-1:WIDTH];
    a_raw   = a_neg_q ? -a_q : a_q;

    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wr_data;
        if (bus.lo_we) lo_d = bus.wr_data;
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = bus.op;
          a_d     = a_abs;
          b_d     = b_abs;
          a_neg_d = sgn_in & bus.src_a[WIDTH-1];
          b_neg_d = sgn_in & bus.src_b[WIDTH-1];
          // Multiplier or dividend sits in the low half and shifts out as we go.
          acc_d   = {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
        end
      end
      CALC: begin
        if (!op_q[1]) begin
          sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end else begin
          sh      = {acc_q, 1'b0};
          rem_try = sh[W2:WIDTH] - {1'b0, b_q};
          if (sh[W2:WIDTH] >= {1'b0, b_q}) begin
            sh[W2:WIDTH] = rem_try;
            sh[0]        = 1'b1;
          end
          acc_d = sh[W2-1:0];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          if (a_neg_q ^ b_neg_q) prod = -acc_q;
          hi_d       = prod[W2-1:WIDTH];
          lo_d       = prod[WIDTH-1:0];
          div_zero_d = 1'b0;
        end else if (b_q == '0) begin
          hi_d       = a_raw;
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else begin
          if (a_neg_q ^ b_neg_q) quo = -acc_q[WIDTH-1:0];
          if (a_neg_q)           rem = -acc_q[W2-1:WIDTH];
          hi_d       = rem;
          lo_d       = quo;
          div_zero_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a transaction-level HI/LO model checked every
// cycle, plus hand-computed results for each directed vector.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {div_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p, q, r;
    case (op)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = ua * ub; return {1'b0, p}; end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        if (op == 2'b10) begin q = sa / sb; r = sa % sb; end
        else             begin q = ua / ub; r = ua % ub; end
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Model: an issued op completes 33 edges after the issuing edge.
  int          m_remain = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0, m_done = 1'b0;
  logic [64:0] m_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_remain <= 0; m_hi <= '0; m_lo <= '0; m_dz <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_remain == 0) begin
        if (bus.hi_we) m_hi <= bus.wr_data;
        if (bus.lo_we) m_lo <= bus.wr_data;
        if (bus.start) begin
          m_res    <= ref_op(bus.op, bus.src_a, bus.src_b);
          m_remain <= 33;
        end
      end else begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          {m_dz, m_hi, m_lo} <= m_res;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_remain != 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("div_zero", 32'(bus.div_zero), 32'(m_dz));
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e_hi, input logic [31:0] e_lo, input bit e_dz,
                       input bit mt_mid, input logic [31:0] mid_hi, input bit mt_issue);
    int n = 0;
    int bc = 0;
    bit got = 1'b0;
    @(negedge clk);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    if (mt_issue) begin bus.hi_we = 1'b1; bus.wr_data = 32'h1234; end
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
        bus.src_a = $urandom; bus.src_b = $urandom;
        if (mt_issue) chk("hi_mt_issue", bus.hi, 32'h1234);
      end
      if (mt_mid && n == 5) begin bus.hi_we = 1'b1; bus.wr_data = 32'hDEAD; end
      if (mt_mid && n == 6) bus.hi_we = 1'b0;
      if (mt_mid && n == 7) chk("hi_we_busy", bus.hi, mid_hi);
      if (bus.done) got = 1'b1;
      else if (bus.busy) bc++;
    end
    chk("timeout", 32'(got), 32'd1);
    chk("latency", 32'(n), 32'd34);
    chk("busy_cycles", 32'(bc), 32'd33);
    chk("res_hi", bus.hi, e_hi);
    chk("res_lo", bus.lo, e_lo);
    chk("res_dz", 32'(bus.div_zero), 32'(e_dz));
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dz", 32'(bus.div_zero), 32'd0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, '0, 1'b0);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, '0, 1'b0);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, '0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, '0, 1'b0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0, '0, 1'b0);
    do_op(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0, '0, 1'b0);
    do_op(2'b11, 32'd100, 32'd0, 32'h64, 32'hFFFFFFFF, 1'b1, 1'b0, '0, 1'b0);
    do_op(2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 1'b1, 32'h64, 1'b0);

    @(negedge clk);
    bus.lo_we = 1'b1; bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("lo_we", bus.lo, 32'h1234);

    do_op(2'b01, 32'd1, 32'd1, 32'h0, 32'd1, 1'b0, 1'b0, '0, 1'b1);

    // Reset mid-operation, with an ignored second start in flight.
    @(negedge clk);
    bus.op = 2'b00; bus.src_a = 32'd5; bus.src_b = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.op = 2'b10; bus.src_a = 32'd100; bus.src_b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_mid", 32'(bus.busy), 32'd1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_hi", bus.hi, 32'h0);
    chk("mid_rst_lo", bus.lo, 32'h0);
    do_op(2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 1'b0, '0, 1'b0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
